spart_rx_fifo: RTL and testbench
================================

Name: spart_rx_fifo

Overview:
- Parametrised successor to the SPART receive path: oversampling serial receiver plus an on-chip receive FIFO.
- Replaces single-byte RDA buffering so the driver can fall behind by up to FIFO_DEPTH characters without loss.
- Adds configurable data width, optional parity, runtime baud divisor and sticky error flags.
- Sits between the rxd pin (from terminal) and the driver-facing databus logic inside spart.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
OVERSAMPLE, 16, baud ticks per bit (even, >=4)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)
DIV_W, 16, divisor width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
divisor  in  DIV_W  baud tick period minus 1, in clk cycles
rxd  in  1  asynchronous serial input, idle high
rd_en  in  1  pop head word when rda=1
clr_err  in  1  one-cycle pulse clears sticky error flags
rd_data  out  DATA_BITS  FIFO head word (show-ahead), valid when rda=1
rda  out  1  FIFO non-empty
count  out  log2(FIFO_DEPTH)+1  FIFO occupancy
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: word arrived while FIFO full

Behaviour:
- Reset (rst=1 at a clk edge) clears: rda=0, count=0, rd_data=0, all error flags 0, FIFO pointers 0, FSM=IDLE, tick counter=divisor, synchroniser FFs=1. A reset mid-frame abandons the frame; no partial word is pushed.
- Baud tick generator: down-counter; tick asserted for one clk when the count is 0, then reloads divisor. A new divisor value takes effect at the next reload. divisor=0 gives a tick every clk.
- rxd passes through a 2-FF synchroniser (rxs). The FSM advances only on tick cycles. A sample counter sc counts ticks within a bit.
- IDLE: at a tick with rxs=0, go to START with sc=0.
- START: at sc=OVERSAMPLE/2-1, sample rxs. If 1 (glitch), return to IDLE with nothing pushed. If 0, sc=0 and go to DATA.
- DATA: sample at sc=OVERSAMPLE-1 and shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at sc=OVERSAMPLE-1. Mismatch against XOR(data)^PARITY_ODD expectation sets the pending parity flag.
- STOP: sample at sc=OVERSAMPLE-1.
  - rxs=1: push the word. parity_err is set if the parity flag is pending. Go to IDLE.
  - rxs=0: set frame_err, discard the word, go to BREAK.
- BREAK: wait for a tick with rxs=1, then go to IDLE.
- Push latency: word visible at rd_data, and rda/count updated, on the clk edge after the stop-sample tick cycle.
- FIFO behaviour:
  - rd_en with rda=1 pops at the clk edge.
  - rd_en with rda=0 is ignored; count never underflows.
  - Push while count=FIFO_DEPTH and no pop in the same cycle: word dropped, overrun set, contents unchanged.
  - Simultaneous push and pop: both occur, count unchanged, no overrun even when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags hold until clr_err or rst. If clr_err and a new error occur in the same cycle, the flag ends set.
- rd_data holds its value when rda=0; it is don't-care to the driver.

Test Plan:
- divisor=3, 8N1, send 0xA5 (64 clk/bit) -> rda rises ~10 bit-times after the start edge; rd_data=0xA5, count=1. Pulse rd_en -> rda=0, count=0.
- Send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads, FIFO_DEPTH=4 -> count=4, overrun=1. Reads return 0x11..0x44 in order; 0x55 is lost. clr_err -> overrun=0.
- Drive rxd low for 20 clk then high (shorter than a half bit of 32 clk) -> FSM returns to IDLE; rda=0, no flags set.
- Frame 0x3C with stop bit driven 0, then idle -> frame_err=1, count=0. A following valid 0x3C is received normally.
- PARITY_EN=1, PARITY_ODD=1, send 0x07 with parity bit 1 -> parity_err=1, word 0x07 pushed. With parity 0 (after clr_err) -> no error.
- Assert rst mid-DATA of 0xF0, release, then send 0x0F -> only 0x0F received, count=1. With FIFO full, issue rd_en and push in the same cycle -> count stays 4, overrun stays 0.

Source files
------------

// File: rtl/spart_rx_fifo.sv
// Oversampling serial receiver feeding a show-ahead receive FIFO.
// Frames are start, DATA_BITS (LSB first), optional parity, one stop bit.
module spart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              divisor,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rda,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       tick_cnt_q;
  logic                   tick;
  logic                   sync1_q, rxs_q;
  logic [SC_W-1:0]        sc_q, sc_d;
  logic [BC_W-1:0]        bc_q, bc_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   pp_q, pp_d;
  logic                   push, fe_set, pe_set;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
  logic                   fe_q, pe_q, ov_q;
  logic                   full, empty, do_pop, do_push, ov_set;

  assign tick = (tick_cnt_q == '0);

  // Receive FSM: every transition is qualified by a baud tick.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bc_d    = bc_q;
    sh_d    = sh_q;
    pp_d    = pp_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    pe_set  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            sc_d    = '0;
            pp_d    = 1'b0;
          end
        end
        S_START: begin
          if (sc_q == SC_HALF) begin
            sc_d = '0;
            bc_d = '0;
            state_d = rxs_q ? S_IDLE : S_DATA;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        S_DATA: begin
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            sh_d = {rxs_q, sh_q[DATA_BITS-1:1]};
            bc_d = bc_q + BC_W'(1);
            if (bc_q == BC_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        S_PARITY: begin
          if (sc_q == SC_LAST) begin
            sc_d    = '0;
            pp_d    = rxs_q ^ (^sh_q) ^ (PARITY_ODD != 0);
            state_d = S_STOP;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        S_STOP: begin
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            if (rxs_q) begin
              push    = 1'b1;
              pe_set  = pp_q;
              state_d = S_IDLE;
            end else begin
              fe_set  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        S_BREAK: begin
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO control; rd_data is recomputed only when the FIFO stays non-empty.
  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    empty    = (count_q == '0);
    do_pop   = rd_en & ~empty;
    do_push  = push & (~full | do_pop);
    ov_set   = push & full & ~do_pop;
    rd_ptr_n = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    rd_data_d = rd_data_q;
    if (count_d != '0) begin
      rd_data_d = (do_push && (wr_ptr_q == rd_ptr_n)) ? sh_q : mem_q[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= divisor;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= S_IDLE;
      sc_q       <= '0;
      bc_q       <= '0;
      sh_q       <= '0;
      pp_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      ov_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      tick_cnt_q <= tick ? divisor : tick_cnt_q - DIV_W'(1);
      sync1_q    <= rxd;
      rxs_q      <= sync1_q;
      state_q    <= state_d;
      sc_q       <= sc_d;
      bc_q       <= bc_d;
      sh_q       <= sh_d;
      pp_q       <= pp_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_n;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      fe_q       <= (fe_q & ~clr_err) | fe_set;
      pe_q       <= (pe_q & ~clr_err) | pe_set;
      ov_q       <= (ov_q & ~clr_err) | ov_set;
      if (do_push) mem_q[wr_ptr_q] <= sh_q;
    end
  end

  assign rd_data    = rd_data_q;
  assign rda        = ~empty;
  assign count      = count_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: an 8N1 instance checked every settled cycle against
// a queue model, plus an 8O1 instance for parity handling.
module tb_spart_rx_fifo;

  localparam int DIV  = 3;
  localparam int TICK = DIV + 1;
  localparam int BITC = 16 * TICK;

  logic        clk = 1'b0;
  logic        rst, rd_en, clr_err, rxd;
  logic        rd_en_p, clr_err_p, rxd_p;
  logic [15:0] divisor;
  logic [7:0]  rd_data, rd_data_p;
  logic        rda, rda_p, frame_err, frame_err_p, parity_err, parity_err_p;
  logic        overrun, overrun_p;
  logic [2:0]  count, count_p;

  always #5 clk = ~clk;

  spart_rx_fifo #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(16),
                  .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .divisor(divisor), .rxd(rxd), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data), .rda(rda), .count(count),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun));

  spart_rx_fifo #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .OVERSAMPLE(16),
                  .FIFO_DEPTH(4), .DIV_W(16)) dut_p (
    .clk(clk), .rst(rst), .divisor(divisor), .rxd(rxd_p), .rd_en(rd_en_p),
    .clr_err(clr_err_p), .rd_data(rd_data_p), .rda(rda_p), .count(count_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int p0 = 0;
  int start_n = 0;
  bit started = 1'b0;
  bit chk_en = 1'b0;

  logic [7:0] exp_q[$];
  logic       m_fe, m_pe, m_ov;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Every settled cycle: outputs of the 8N1 instance against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("rda", {31'd0, rda}, {31'd0, exp_q.size() != 0});
      chk("count", {29'd0, count}, exp_q.size());
      if (exp_q.size() != 0) chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q[0]});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
      chk("parity_err", {31'd0, parity_err}, {31'd0, m_pe});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    rxd = 1'b1;
    rxd_p = 1'b1;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    p0 = cyc;
    rst = 1'b0;
    exp_q.delete();
    m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    chk_en = 1'b1;
  endtask

  // Drives start, data, optional parity and stop; stops after nsend bits.
  // Start edge is placed so the tick grid makes the stop sample 610 clocks
  // after the first posedge of the start bit (8N1).
  task automatic frame(input bit inst, input logic [7:0] data, input bit has_par,
                       input bit par, input bit stopb, input int nsend);
    logic b [11];
    int   nb;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = data[i];
    nb = 9;
    if (has_par) begin b[nb] = par; nb++; end
    b[nb] = stopb; nb++;
    if (nsend < nb) nb = nsend;
    @(negedge clk);
    while (((cyc + 1 - p0) % TICK) != 2) @(negedge clk);
    start_n = cyc + 1;
    started = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (inst) rxd_p = b[i]; else rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    if (inst) rxd_p = 1'b1; else rxd = 1'b1;
    started = 1'b0;
  endtask

  task automatic send8(input logic [7:0] data, input bit stopb);
    chk_en = 1'b0;
    frame(1'b0, data, 1'b0, 1'b0, stopb, 10);
    repeat (16) @(negedge clk);
    if (stopb) begin
      if (exp_q.size() < 4) exp_q.push_back(data);
      else m_ov = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
    chk_en = 1'b1;
  endtask

  task automatic rd_main();
    @(negedge clk) rd_en = 1'b1;
    @(posedge clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic clr_main();
    @(negedge clk) clr_err = 1'b1;
    @(posedge clk);
    m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    @(negedge clk) clr_err = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rxd = 1'b1;
    rd_en_p = 1'b0; clr_err_p = 1'b0; rxd_p = 1'b1;
    divisor = 16'(DIV);
    m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    chk("reset_rda", {31'd0, rda}, 0);
    chk("reset_count", {29'd0, count}, 0);
    chk("reset_rd_data", {24'd0, rd_data}, 0);
    chk("reset_flags", {29'd0, frame_err, parity_err, overrun}, 0);

    // Single 0xA5 with exact push latency, then a read.
    fork
      send8(8'hA5, 1'b1);
      begin
        wait (started);
        while (cyc != start_n + 609) @(negedge clk);
        chk("a5_rda_before_push", {31'd0, rda}, 0);
        @(negedge clk);
        chk("a5_rda_at_push", {31'd0, rda}, 1);
        chk("a5_data_at_push", {24'd0, rd_data}, 32'hA5);
        chk("a5_count_at_push", {29'd0, count}, 1);
      end
    join
    rd_main();
    chk("a5_rda_after_read", {31'd0, rda}, 0);
    chk("a5_count_after_read", {29'd0, count}, 0);
    rd_main();
    chk("empty_read_count", {29'd0, count}, 0);

    // Five words into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send8(8'(i * 8'h11), 1'b1);
    chk("fill_count", {29'd0, count}, 4);
    chk("fill_overrun", {31'd0, overrun}, 1);
    chk("fill_head", {24'd0, rd_data}, 32'h11);
    for (int i = 0; i < 4; i++) rd_main();
    chk("drain_rda", {31'd0, rda}, 0);
    clr_main();
    chk("clr_overrun", {31'd0, overrun}, 0);

    // Short low glitch on rxd.
    @(negedge clk) rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    chk("glitch_rda", {31'd0, rda}, 0);
    chk("glitch_flags", {29'd0, frame_err, parity_err, overrun}, 0);

    // Framing error, then a good frame.
    send8(8'h3C, 1'b0);
    chk("ferr_flag", {31'd0, frame_err}, 1);
    chk("ferr_count", {29'd0, count}, 0);
    send8(8'h3C, 1'b1);
    chk("after_ferr_data", {24'd0, rd_data}, 32'h3C);
    chk("after_ferr_count", {29'd0, count}, 1);
    rd_main();
    clr_main();

    // Odd parity instance: 0x07 needs parity 0.
    frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 11);
    repeat (16) @(negedge clk);
    chk("par_bad_flag", {31'd0, parity_err_p}, 1);
    chk("par_bad_rda", {31'd0, rda_p}, 1);
    chk("par_bad_data", {24'd0, rd_data_p}, 32'h07);
    chk("par_bad_ferr", {31'd0, frame_err_p}, 0);
    rd_en_p = 1'b1;
    @(negedge clk) rd_en_p = 1'b0;
    clr_err_p = 1'b1;
    @(negedge clk) clr_err_p = 1'b0;
    chk("par_clr", {31'd0, parity_err_p}, 0);
    chk("par_pop", {29'd0, count_p}, 0);
    frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 11);
    repeat (16) @(negedge clk);
    chk("par_good_flag", {31'd0, parity_err_p}, 0);
    chk("par_good_data", {24'd0, rd_data_p}, 32'h07);
    chk("par_good_count", {29'd0, count_p}, 1);

    // Reset in the middle of 0xF0's data bits.
    chk_en = 1'b0;
    frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 6);
    do_reset();
    send8(8'h0F, 1'b1);
    chk("rst_mid_count", {29'd0, count}, 1);
    chk("rst_mid_data", {24'd0, rd_data}, 32'h0F);
    rd_main();

    // Full FIFO with a pop landing on the push edge.
    for (int i = 1; i <= 4; i++) send8(8'(i * 8'h11), 1'b1);
    fork
      send8(8'h99, 1'b1);
      begin
        wait (started);
        while (cyc != start_n + 609) @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        void'(exp_q.pop_front());
        @(negedge clk) rd_en = 1'b0;
      end
    join
    chk("simul_count", {29'd0, count}, 4);
    chk("simul_overrun", {31'd0, overrun}, 0);
    chk("simul_head", {24'd0, rd_data}, 32'h22);
    for (int i = 0; i < 4; i++) rd_main();
    chk("final_empty", {31'd0, rda}, 0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
